// File: rtl/tug_match_ctrl.sv
// rtl/tug_match_ctrl.sv - tug-of-war match sequencer: press gating, round scoring, hold/clear, HEX digits.
// Optional CPU right-hand opponent built when CPU_OPPONENT_EN is defined.
module tug_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 16,
  parameter int CPU_BASE    = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       L,
  input  logic       R,
  input  logic       leftWin,
  input  logic       rightWin,
  input  logic [2:0] cpuLevel,
  output logic       Lgo,
  output logic       Rgo,
  output logic       roundReset,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       matchOver,
  output logic       matchWinner,
  output logic [6:0] HEXL,
  output logic [6:0] HEXR
);

  typedef enum logic [1:0] {PLAY, HOLD, CLEAR, OVER} state_t;

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          r_press;

`ifdef CPU_OPPONENT_EN
  localparam int TW = $clog2(CPU_BASE + 1);

  logic [7:0]    lfsr;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          unused_r;

  // The CPU replaces the right player; its press enters the same gating path as R.
  assign tick     = (tick_cnt == TW'(CPU_BASE - 1));
  assign r_press  = tick && (lfsr[2:0] < cpuLevel);
  assign unused_r = R;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr     <= 8'hA5;
      tick_cnt <= '0;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end
`else
  logic unused_cpu;

  assign unused_cpu = ^cpuLevel;
  assign r_press    = R;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= PLAY;
      hold_cnt    <= '0;
      Lgo         <= 1'b0;
      Rgo         <= 1'b0;
      roundReset  <= 1'b0;
      leftScore   <= 4'd0;
      rightScore  <= 4'd0;
      matchOver   <= 1'b0;
      matchWinner <= 1'b0;
    end else begin
      Lgo        <= 1'b0;
      Rgo        <= 1'b0;
      roundReset <= 1'b0;
      case (state)
        PLAY: begin
          Lgo <= L & ~r_press;
          Rgo <= r_press & ~L;
          if (leftWin && rightWin) begin
            state    <= HOLD;
            hold_cnt <= HW'(HOLD_CYCLES - 1);
          end else if (leftWin) begin
            if (leftScore < 4'(WIN_SCORE)) leftScore <= leftScore + 4'd1;
            if (leftScore + 4'd1 >= 4'(WIN_SCORE)) begin
              state       <= OVER;
              matchOver   <= 1'b1;
              matchWinner <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES - 1);
            end
          end else if (rightWin) begin
            if (rightScore < 4'(WIN_SCORE)) rightScore <= rightScore + 4'd1;
            if (rightScore + 4'd1 >= 4'(WIN_SCORE)) begin
              state       <= OVER;
              matchOver   <= 1'b1;
              matchWinner <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES - 1);
            end
          end
        end
        // Counter loads HOLD_CYCLES-1 on entry, so HOLD lasts HOLD_CYCLES cycles.
        HOLD: begin
          if (hold_cnt == '0) begin
            state      <= CLEAR;
            roundReset <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        CLEAR:   state <= PLAY;
        OVER:    state <= OVER;
        default: state <= PLAY;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign HEXL = seg7(leftScore);
  assign HEXR = seg7(rightScore);

endmodule
